// File: rtl/nios_sys_nios2_qsys_0_oci_dct_sequencer.sv
// OCI DCT sequencer: packs 2-bit trace codes into 30-bit words behind a valid/ready
// output register, with flush, overflow accounting and an end-of-test drain sequence.
module nios_sys_nios2_qsys_0_oci_dct_sequencer #(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      code_valid,
  input  logic [CODE_W-1:0]         code,
  input  logic                      flush_req,
  input  logic                      test_end_req,
  input  logic                      word_ready,
  output logic                      word_valid,
  output logic [CODE_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_ending,
  output logic                      test_has_ended,
  output logic                      overflow,
  input  logic                      overflow_clr,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int unsigned BUF_W = CODE_W * SLOTS;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SLOTS);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_ENDING  = 2'd1;
  localparam logic [1:0] ST_ENDED   = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [BUF_W-1:0]  asm_buf, asm_buf_nxt;
  logic [CNT_W-1:0]  asm_cnt, asm_cnt_nxt;
  logic              flush_pend, flush_pend_nxt;
  logic              word_valid_nxt;
  logic [BUF_W-1:0]  dct_buffer_nxt;
  logic [CNT_W-1:0]  dct_count_nxt;
  logic              overflow_nxt;
  logic [DROP_W-1:0] drop_count_nxt;
  logic              test_ending_nxt, test_has_ended_nxt;

  logic              out_free, asm_full, code_in, drop, flush_want;
  logic [BUF_W-1:0]  merge_buf;
  logic [CNT_W-1:0]  merge_cnt;

  // Next-state, datapath and output computation
  always_comb begin
    state_nxt      = state;
    asm_buf_nxt    = asm_buf;
    asm_cnt_nxt    = asm_cnt;
    flush_pend_nxt = flush_pend;
    word_valid_nxt = word_valid & ~word_ready;
    dct_buffer_nxt = dct_buffer;
    dct_count_nxt  = dct_count;
    overflow_nxt   = overflow;
    drop_count_nxt = drop_count;
    merge_buf      = asm_buf;
    merge_cnt      = asm_cnt;

    out_free   = ~word_valid | word_ready;
    asm_full   = (asm_cnt == CNT_FULL);
    code_in    = code_valid & enable & (state == ST_CAPTURE);
    drop       = code_in & asm_full & ~out_free;
    flush_want = flush_req | flush_pend | (state == ST_ENDING);

    if (asm_full && out_free) begin
      // Full word moves out; a same-cycle code seeds the fresh assembly
      word_valid_nxt = 1'b1;
      dct_buffer_nxt = asm_buf;
      dct_count_nxt  = asm_cnt;
      asm_buf_nxt    = code_in ? BUF_W'(code) : '0;
      asm_cnt_nxt    = code_in ? CNT_W'(1) : '0;
      flush_pend_nxt = 1'b0;
    end else begin
      if (code_in && !asm_full) begin
        merge_buf = {asm_buf[BUF_W-CODE_W-1:0], code};
        merge_cnt = asm_cnt + CNT_W'(1);
      end
      asm_buf_nxt = merge_buf;
      asm_cnt_nxt = merge_cnt;
      if (flush_want && (merge_cnt != '0)) begin
        if (out_free) begin
          word_valid_nxt = 1'b1;
          dct_buffer_nxt = merge_buf;
          dct_count_nxt  = merge_cnt;
          asm_buf_nxt    = '0;
          asm_cnt_nxt    = '0;
          flush_pend_nxt = 1'b0;
        end else begin
          flush_pend_nxt = 1'b1;
        end
      end else begin
        flush_pend_nxt = 1'b0;
      end
    end

    // A drop in the same cycle as a clear leaves one recorded drop
    if (drop) begin
      overflow_nxt   = 1'b1;
      drop_count_nxt = overflow_clr ? DROP_W'(1)
                     : ((drop_count == DROP_MAX) ? DROP_MAX : drop_count + DROP_W'(1));
    end else if (overflow_clr) begin
      overflow_nxt   = 1'b0;
      drop_count_nxt = '0;
    end

    case (state)
      ST_CAPTURE: if (test_end_req) state_nxt = ST_ENDING;
      ST_ENDING:  if ((asm_cnt == '0) && out_free) state_nxt = ST_ENDED;
      ST_ENDED:   state_nxt = ST_ENDED;
      default:    state_nxt = ST_CAPTURE;
    endcase

    test_ending_nxt    = (state_nxt != ST_CAPTURE);
    test_has_ended_nxt = (state_nxt == ST_ENDED);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_CAPTURE;
      asm_buf        <= '0;
      asm_cnt        <= '0;
      flush_pend     <= 1'b0;
      word_valid     <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      overflow       <= 1'b0;
      drop_count     <= '0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_nxt;
      asm_buf        <= asm_buf_nxt;
      asm_cnt        <= asm_cnt_nxt;
      flush_pend     <= flush_pend_nxt;
      word_valid     <= word_valid_nxt;
      dct_buffer     <= dct_buffer_nxt;
      dct_count      <= dct_count_nxt;
      overflow       <= overflow_nxt;
      drop_count     <= drop_count_nxt;
      test_ending    <= test_ending_nxt;
      test_has_ended <= test_has_ended_nxt;
    end
  end

endmodule

// File: tb/tb_nios_sys_nios2_qsys_0_oci_dct_sequencer.sv
// Scoreboard bench for the DCT sequencer: queue-based reference model predicts words,
// a decoupled monitor checks each delivered word; status flags checked every cycle.
module tb_nios_sys_nios2_qsys_0_oci_dct_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, code_valid = 1'b0, flush_req = 1'b0, test_end_req = 1'b0;
  logic        word_ready = 1'b0, overflow_clr = 1'b0;
  logic [1:0]  code = 2'b00;
  logic        word_valid, test_ending, test_has_ended, overflow;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_count;

  nios_sys_nios2_qsys_0_oci_dct_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .code_valid(code_valid), .code(code),
    .flush_req(flush_req), .test_end_req(test_end_req), .word_ready(word_ready),
    .word_valid(word_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed { logic [29:0] b; logic [3:0] c; } word_t;
  word_t exp_q[$];

  // Reference model: codes waiting in assembly, output-slot occupancy, phase 0/1/2
  int m_asm[$];
  bit m_valid, m_fpend, m_ovf;
  int m_state, m_drops;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_asm.delete();
    m_valid = 0; m_fpend = 0; m_ovf = 0; m_state = 0; m_drops = 0;
    exp_q.delete();
  endtask

  task automatic m_emit();
    word_t w;
    w.b = '0;
    foreach (m_asm[i]) w.b = (w.b << 2) | 30'(m_asm[i]);
    w.c = 4'(m_asm.size());
    exp_q.push_back(w);
    m_asm.delete();
    m_valid = 1; m_fpend = 0;
  endtask

  task automatic cycle(input bit cv, input bit [1:0] cd, input bit en, input bit fl,
                       input bit te, input bit rdy, input bit clr);
    bit free, acc, emitted, dropped;
    int pre, nst;
    @(negedge clk);
    chk("word_valid", word_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
    chk("test_ending", test_ending, m_state != 0);
    chk("test_has_ended", test_has_ended, m_state == 2);
    code_valid = cv; code = cd; enable = en; flush_req = fl;
    test_end_req = te; word_ready = rdy; overflow_clr = clr;

    free = !m_valid || rdy;
    acc  = cv && en && (m_state == 0);
    pre  = m_asm.size();
    emitted = 0; dropped = 0; nst = m_state;
    if (m_state == 0 && te) nst = 1;
    else if (m_state == 1 && pre == 0 && free) nst = 2;
    if (pre == 15 && free) begin
      m_emit(); emitted = 1;
      if (acc) m_asm.push_back(int'(cd));
    end else begin
      if (acc) begin
        if (pre < 15) m_asm.push_back(int'(cd));
        else dropped = 1;
      end
      if ((fl || m_fpend || m_state == 1) && m_asm.size() > 0) begin
        if (free) begin m_emit(); emitted = 1; end
        else m_fpend = 1;
      end else m_fpend = 0;
    end
    if (!emitted && rdy) m_valid = 0;
    if (dropped) begin
      m_ovf = 1;
      m_drops = clr ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf = 0; m_drops = 0;
    end
    m_state = nst;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 2'b00, 1, 0, 0, rdy, 0);
  endtask

  task automatic codes(input int n, input bit [1:0] cd, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1, cd, 1, 0, 0, rdy, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " word_valid"}, word_valid, 0);
    chk({tag, " dct_buffer"}, dct_buffer, 0);
    chk({tag, " dct_count"}, dct_count, 0);
    chk({tag, " test_ending"}, test_ending, 0);
    chk({tag, " test_has_ended"}, test_has_ended, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " drop_count"}, drop_count, 0);
  endtask

  // Reset asserted asynchronously in the middle of the low phase
  task automatic do_reset();
    @(negedge clk);
    code_valid = 0; flush_req = 0; test_end_req = 0; overflow_clr = 0; word_ready = 0;
    #3 reset = 1'b1;
    #1 check_zero("reset");
    m_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare every accepted word against the scoreboard queue
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && word_valid && word_ready) begin
        if (exp_q.size() == 0) chk("unexpected word", dct_buffer, 0 - 1);
        else begin
          w = exp_q.pop_front();
          chk("dct_buffer", dct_buffer, w.b);
          chk("dct_count", dct_count, w.c);
        end
      end
    end
  end

  initial begin
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("init");
    reset = 1'b0;

    // Full word of 01 codes with the sink always ready
    codes(15, 2'b01, 1);
    idle(1, 1);
    idle(1, 1);
    chk("t1 buffer", dct_buffer, 30'h15555555);
    chk("t1 count", dct_count, 15);
    idle(2, 1);

    // Partial flush, then a second flush with nothing assembled
    cycle(1, 2'b11, 1, 0, 0, 1, 0);
    cycle(1, 2'b10, 1, 0, 0, 1, 0);
    cycle(1, 2'b01, 1, 0, 0, 1, 0);
    cycle(0, 2'b00, 1, 1, 0, 1, 0);
    idle(1, 1);
    chk("t2 buffer", dct_buffer, 30'h39);
    chk("t2 count", dct_count, 3);
    cycle(0, 2'b00, 1, 1, 0, 1, 0);
    idle(3, 1);

    // Stalled sink: output word held, assembly fills, the 31st code drops
    codes(31, 2'b10, 0);
    idle(1, 0);
    chk("t3 drop_count", drop_count, 1);
    chk("t3 overflow", overflow, 1);
    chk("t3 held buffer", dct_buffer, 30'h2AAAAAAA);
    idle(5, 1);
    cycle(0, 2'b00, 1, 0, 0, 1, 1);
    idle(2, 1);

    // End-of-test drains the partial word, then codes are ignored
    codes(5, 2'b11, 0);
    cycle(0, 2'b00, 1, 0, 1, 0, 0);
    idle(2, 0);
    chk("t4 ending", test_ending, 1);
    chk("t4 buffer", dct_buffer, 30'h3FF);
    idle(3, 1);
    codes(20, 2'b10, 1);
    idle(1, 1);
    chk("t4 ended", test_has_ended, 1);
    chk("t4 no drops", drop_count, 0);

    // Reset mid-word, then a clean word
    do_reset();
    codes(21, 2'b01, 0);
    do_reset();
    codes(15, 2'b10, 1);
    idle(3, 1);

    // Saturating drop counter, then clear
    codes(330, 2'b11, 0);
    idle(1, 0);
    chk("t6 saturated", drop_count, 255);
    cycle(0, 2'b00, 1, 0, 0, 0, 1);
    idle(1, 0);
    chk("t6 cleared", drop_count, 0);
    chk("t6 overflow cleared", overflow, 0);
    idle(4, 1);

    // Randomized traffic with periodic resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) do_reset();
      cycle($urandom_range(0, 1) == 1, 2'($urandom), $urandom_range(0, 7) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    // Drain: end the test so any partial word is flushed
    cycle(0, 2'b00, 1, 0, 1, 1, 0);
    idle(40, 1);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
